// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT datapath types and constants
package fft_pkg;
    localparam int DW = 16;
    localparam int BFLY_LATENCY = 3;
    localparam int COEFF_FRAC = DW - 1;
    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;
endpackage

// File: rtl/cmult_pipe.sv
// cmult_pipe: two-stage registered complex multiply b*W (Q1.(DW-1) twiddle) with a and valid forwarded
module cmult_pipe
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] a_re,
    input  logic signed [DATA_WIDTH-1:0] a_im,
    input  logic signed [DATA_WIDTH-1:0] b_re,
    input  logic signed [DATA_WIDTH-1:0] b_im,
    input  logic signed [DATA_WIDTH-1:0] w_re,
    input  logic signed [DATA_WIDTH-1:0] w_im,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] a_dly_re,
    output logic signed [DATA_WIDTH-1:0] a_dly_im,
    output logic signed [DATA_WIDTH-1:0] bw_re,
    output logic signed [DATA_WIDTH-1:0] bw_im
);
    localparam int P = 2 * DATA_WIDTH;
    localparam int FRAC = DATA_WIDTH - 1;

    logic signed [P-1:0]          p_rr, p_ii, p_ri, p_ir;
    logic signed [DATA_WIDTH-1:0] s1_a_re, s1_a_im;
    logic                         s1_valid;

    // S1: register the four partial products alongside a and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            p_rr     <= '0;
            p_ii     <= '0;
            p_ri     <= '0;
            p_ir     <= '0;
            s1_a_re  <= '0;
            s1_a_im  <= '0;
            s1_valid <= 1'b0;
        end else if (en) begin
            p_rr     <= b_re * w_re;
            p_ii     <= b_im * w_im;
            p_ri     <= b_re * w_im;
            p_ir     <= b_im * w_re;
            s1_a_re  <= a_re;
            s1_a_im  <= a_im;
            s1_valid <= in_valid;
        end
    end

    // S2: combine products and drop FRAC LSBs (floor); the dropped MSB makes -1*-1 wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            bw_re     <= '0;
            bw_im     <= '0;
            a_dly_re  <= '0;
            a_dly_im  <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            bw_re     <= DATA_WIDTH'((p_rr - p_ii) >>> FRAC);
            bw_im     <= DATA_WIDTH'((p_ri + p_ir) >>> FRAC);
            a_dly_re  <= s1_a_re;
            a_dly_im  <= s1_a_im;
            out_valid <= s1_valid;
        end
    end
endmodule

// File: rtl/butterfly2_dit_pipe.sv
// butterfly2_dit_pipe: pipelined radix-2 DIT butterfly c = a + b*W, d = a - b*W; BFLY_DIT_SCALE_EN halves outputs
module butterfly2_dit_pipe
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] a_re,
    input  logic signed [DATA_WIDTH-1:0] a_im,
    input  logic signed [DATA_WIDTH-1:0] b_re,
    input  logic signed [DATA_WIDTH-1:0] b_im,
    input  logic signed [DATA_WIDTH-1:0] coeff_re,
    input  logic signed [DATA_WIDTH-1:0] coeff_im,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] c_re,
    output logic signed [DATA_WIDTH-1:0] c_im,
    output logic signed [DATA_WIDTH-1:0] d_re,
    output logic signed [DATA_WIDTH-1:0] d_im
);
    logic                         en;
    logic                         s2_valid;
    logic signed [DATA_WIDTH-1:0] s2_a_re, s2_a_im, bw_re, bw_im;
    logic signed [DATA_WIDTH-1:0] c_re_n, c_im_n, d_re_n, d_im_n;

    assign en       = out_ready || !out_valid;
    assign in_ready = en;

    cmult_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_cmult (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .a_re     (a_re),
        .a_im     (a_im),
        .b_re     (b_re),
        .b_im     (b_im),
        .w_re     (coeff_re),
        .w_im     (coeff_im),
        .out_valid(s2_valid),
        .a_dly_re (s2_a_re),
        .a_dly_im (s2_a_im),
        .bw_re    (bw_re),
        .bw_im    (bw_im)
    );

`ifdef BFLY_DIT_SCALE_EN
    logic signed [DATA_WIDTH:0] sum_re, sum_im, dif_re, dif_im;

    // one guard bit keeps the sum exact before the halving shift
    always_comb begin
        sum_re = (DATA_WIDTH+1)'(s2_a_re) + (DATA_WIDTH+1)'(bw_re);
        sum_im = (DATA_WIDTH+1)'(s2_a_im) + (DATA_WIDTH+1)'(bw_im);
        dif_re = (DATA_WIDTH+1)'(s2_a_re) - (DATA_WIDTH+1)'(bw_re);
        dif_im = (DATA_WIDTH+1)'(s2_a_im) - (DATA_WIDTH+1)'(bw_im);
        c_re_n = DATA_WIDTH'(sum_re >>> 1);
        c_im_n = DATA_WIDTH'(sum_im >>> 1);
        d_re_n = DATA_WIDTH'(dif_re >>> 1);
        d_im_n = DATA_WIDTH'(dif_im >>> 1);
    end
`else
    // plain wrapping add/sub at DATA_WIDTH bits
    always_comb begin
        c_re_n = s2_a_re + bw_re;
        c_im_n = s2_a_im + bw_im;
        d_re_n = s2_a_re - bw_re;
        d_im_n = s2_a_im - bw_im;
    end
`endif

    // S3: output register, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            c_re      <= '0;
            c_im      <= '0;
            d_re      <= '0;
            d_im      <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            c_re      <= c_re_n;
            c_im      <= c_im_n;
            d_re      <= d_re_n;
            d_im      <= d_im_n;
            out_valid <= s2_valid;
        end
    end
endmodule
